// File: rtl/bsg_upstream_pkg.sv
// Shared types and elaboration helpers for the upstream serializer.
package bsg_upstream_pkg;

    typedef enum logic {IDLE, SEND} state_e;

    function automatic int beats(input int dw, input int ch, input int cw);
        return dw / (ch * cw);
    endfunction

    function automatic int beat_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit width_ok(input int dw, input int ch, input int cw);
        return (dw >= ch * cw) && ((dw % (ch * cw)) == 0);
    endfunction

endpackage

// File: rtl/bsg_upstream_credit_counter.sv
// Saturating token-credit counter with sticky overflow flag.
module bsg_upstream_credit_counter #(
    parameter int CREDITS = 16,
    parameter int CW      = $clog2(CREDITS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] cnt,
    output logic          ovf
);

    localparam logic [CW-1:0] FULL = CW'(CREDITS);
    localparam logic [CW-1:0] ONE  = CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= FULL;
            ovf <= 1'b0;
        end else begin
            // A token with nothing outstanding means the far end miscounted.
            if (inc && cnt == FULL) ovf <= 1'b1;
            if (inc && !dec && cnt != FULL) cnt <= cnt + ONE;
            else if (dec && !inc) cnt <= cnt - ONE;
        end
    end

endmodule

// File: rtl/bsg_upstream_serializer.sv
// Core words to CHANNELS x CH_WIDTH beats, with a one-word skid buffer
// and token-credit flow control toward the far end.
module bsg_upstream_serializer
    import bsg_upstream_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CHANNELS   = 2,
    parameter int CH_WIDTH   = 8,
    parameter int CREDITS    = 16,
    parameter int CNT_WIDTH  = 7
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           core_valid_in,
    input  logic [DATA_WIDTH-1:0]          core_data_in,
    output logic                           core_ready_out,
    input  logic                           io_token,
    output logic                           io_valid_out,
    output logic [CHANNELS*CH_WIDTH-1:0]   io_data_out,
    output logic [$clog2(CREDITS+1)-1:0]   credit_cnt,
    output logic [CNT_WIDTH-1:0]           sent_cnt,
    output logic                           err_credit_ovf
);

    localparam int BEATS = beats(DATA_WIDTH, CHANNELS, CH_WIDTH);
    localparam int BW    = beat_width(BEATS);
    localparam int CW    = $clog2(CREDITS + 1);
    localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

    if (!width_ok(DATA_WIDTH, CHANNELS, CH_WIDTH)) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of CHANNELS*CH_WIDTH");
    end

    state_e                state;
    logic [BW-1:0]         beat;
    logic [BW-1:0]         cur_beat;
    logic                  active_valid;
    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] active_data;
    logic [DATA_WIDTH-1:0] skid_data;
    logic [DATA_WIDTH-1:0] cur_data;
    logic                  src_skid;
    logic                  start;
    logic                  busy;
    logic                  last;
    logic                  launch;
    logic                  accept;
    logic                  credit_avail;
    logic                  cont;

    assign core_ready_out = !rst && !skid_valid;
    assign accept         = core_valid_in && core_ready_out;
    assign src_skid       = (state == IDLE) && !active_valid;
    assign start          = !rst && (state == IDLE)
                          && (active_valid || skid_valid)
                          && (credit_cnt != '0);
    assign busy           = start || (!rst && state == SEND);
    assign cur_beat       = (state == SEND) ? beat : '0;
    assign last           = busy && (cur_beat == LAST);
    assign launch         = start || (busy && state == SEND && beat == '0);
    // Credit seen by next cycle's launch: this cycle's token counts.
    assign credit_avail   = io_token || (credit_cnt > CW'(launch));
    assign cont           = last && skid_valid && !(start && src_skid)
                          && credit_avail;
    assign cur_data       = src_skid ? skid_data : active_data;
    assign io_valid_out   = busy;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        assign io_data_out[c*CH_WIDTH +: CH_WIDTH] = busy
            ? CH_WIDTH'(cur_data >> ((c * BEATS + int'(cur_beat)) * CH_WIDTH))
            : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            beat         <= '0;
            active_valid <= 1'b0;
            skid_valid   <= 1'b0;
            sent_cnt     <= '0;
        end else begin
            if (launch) sent_cnt <= sent_cnt + CNT_WIDTH'(1);
            if (accept) begin
                if (state == IDLE && !active_valid) begin
                    active_valid <= 1'b1;
                    active_data  <= core_data_in;
                end else begin
                    skid_valid <= 1'b1;
                    skid_data  <= core_data_in;
                end
            end
            if (start && src_skid) begin
                active_valid <= 1'b1;
                active_data  <= skid_data;
                skid_valid   <= 1'b0;
            end
            if (last) begin
                beat <= '0;
                if (cont) begin
                    state       <= SEND;
                    active_data <= skid_data;
                    skid_valid  <= 1'b0;
                end else begin
                    state        <= IDLE;
                    active_valid <= 1'b0;
                end
            end else if (busy) begin
                state <= SEND;
                beat  <= cur_beat + BW'(1);
            end
        end
    end

    bsg_upstream_credit_counter #(
        .CREDITS (CREDITS),
        .CW      (CW)
    ) u_credit (
        .clk (clk),
        .rst (rst),
        .inc (io_token),
        .dec (launch),
        .cnt (credit_cnt),
        .ovf (err_credit_ovf)
    );

endmodule

// File: tb/tb_bsg_upstream_serializer.sv
// Scoreboard bench for bsg_upstream_serializer (default and 4x4-bit configs).
module tb_bsg_upstream_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, valid, token, ready, io_valid, ovf;
    logic [63:0] data;
    logic [15:0] io_data;
    logic [4:0]  credit;
    logic [6:0]  sent;

    logic        rst_b, valid_b, token_b, ready_b, io_valid_b, ovf_b;
    logic [31:0] data_b;
    logic [15:0] io_data_b;
    logic [4:0]  credit_b;
    logic [6:0]  sent_b;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q[$];

    int n, cnt, ret, cyc;
    logic [6:0] prev;
    logic [15:0] w1 [4];

    bsg_upstream_serializer dut (
        .clk            (clk),
        .rst            (rst),
        .core_valid_in  (valid),
        .core_data_in   (data),
        .core_ready_out (ready),
        .io_token       (token),
        .io_valid_out   (io_valid),
        .io_data_out    (io_data),
        .credit_cnt     (credit),
        .sent_cnt       (sent),
        .err_credit_ovf (ovf)
    );

    bsg_upstream_serializer #(
        .DATA_WIDTH (32),
        .CHANNELS   (4),
        .CH_WIDTH   (4)
    ) dut_b (
        .clk            (clk),
        .rst            (rst_b),
        .core_valid_in  (valid_b),
        .core_data_in   (data_b),
        .core_ready_out (ready_b),
        .io_token       (token_b),
        .io_valid_out   (io_valid_b),
        .io_data_out    (io_data_b),
        .credit_cnt     (credit_b),
        .sent_cnt       (sent_b),
        .err_credit_ovf (ovf_b)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pop the current beat, then record beats of a word about to be accepted.
    always @(negedge clk) begin
        if (io_valid) begin
            if (exp_q.size() == 0) check("beat_unexpected", 64'd1, 64'd0);
            else check("beat", 64'(io_data), 64'(exp_q.pop_front()));
        end else begin
            check("idle_zero", 64'(io_data), 64'd0);
        end
        if (valid && ready) begin
            for (int k = 0; k < 4; k++)
                exp_q.push_back({data[(4+k)*8 +: 8], data[k*8 +: 8]});
        end
    end

    task automatic send_word(input logic [63:0] d);
        valid = 1'b1;
        data  = d;
        @(negedge clk);
        for (int i = 0; i < 200 && !ready; i++) @(negedge clk);
        check("send_ready", 64'(ready), 64'd1);
        @(posedge clk);
        #1 valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; valid = 1'b0; token = 1'b0; data = '0;
        rst_b = 1'b1; valid_b = 1'b0; token_b = 1'b0; data_b = '0;
        w1[0] = 16'h5511; w1[1] = 16'h6622; w1[2] = 16'h7733; w1[3] = 16'h8844;

        @(negedge clk);
        check("rst_valid", 64'(io_valid), 64'd0);
        check("rst_data", 64'(io_data), 64'd0);
        check("rst_ready", 64'(ready), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 64'(ready), 64'd1);
        check("post_rst_credit", 64'(credit), 64'd16);
        check("post_rst_sent", 64'(sent), 64'd0);
        check("post_rst_ovf", 64'(ovf), 64'd0);

        // Single word, literal beat values
        @(posedge clk);
        #1 valid = 1'b1; data = 64'h8877_6655_4433_2211;
        @(posedge clk);
        #1 valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("w1_valid", 64'(io_valid), 64'd1);
            check("w1_beat", 64'(io_data), 64'(w1[k]));
        end
        @(negedge clk);
        check("w1_done", 64'(io_valid), 64'd0);
        check("w1_credit", 64'(credit), 64'd15);
        check("w1_sent", 64'(sent), 64'd1);

        // 17 back-to-back words against 16 credits
        do_reset();
        fork
            for (int i = 0; i < 17; i++) send_word({$urandom, $urandom});
            begin
                n = 0;
                @(negedge clk);
                while (!io_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                check("cont_first", 64'(io_valid), 64'd1);
                cnt = 0;
                repeat (64) begin
                    if (io_valid) cnt++;
                    @(negedge clk);
                end
                check("cont_no_bubble", 64'(cnt), 64'd64);
                check("cont_stall_valid", 64'(io_valid), 64'd0);
                check("cont_stall_ready", 64'(ready), 64'd0);
                check("cont_stall_credit", 64'(credit), 64'd0);
                check("cont_stall_sent", 64'(sent), 64'd16);
            end
        join
        @(posedge clk);
        #1 token = 1'b1;
        @(posedge clk);
        #1 token = 1'b0;
        @(negedge clk);
        check("tok_launch", 64'(io_valid), 64'd1);
        check("tok_launch_credit", 64'(credit), 64'd1);
        repeat (4) @(negedge clk);
        check("w17_done", 64'(io_valid), 64'd0);
        check("w17_credit", 64'(credit), 64'd0);
        check("w17_sent", 64'(sent), 64'd17);

        // Token in the same cycle as a first beat
        repeat (3) begin
            @(posedge clk);
            #1 token = 1'b1;
        end
        @(posedge clk);
        #1 token = 1'b0; valid = 1'b1; data = {$urandom, $urandom};
        @(posedge clk);
        #1 valid = 1'b0; token = 1'b1;
        @(negedge clk);
        check("same_first_beat", 64'(io_valid), 64'd1);
        check("same_credit_before", 64'(credit), 64'd3);
        @(posedge clk);
        #1 token = 1'b0;
        @(negedge clk);
        check("same_credit_after", 64'(credit), 64'd3);
        repeat (4) @(negedge clk);

        // Token with a full credit count
        do_reset();
        @(posedge clk);
        #1 token = 1'b1;
        @(posedge clk);
        #1 token = 1'b0;
        @(negedge clk);
        check("ovf_set", 64'(ovf), 64'd1);
        check("ovf_credit", 64'(credit), 64'd16);
        repeat (5) @(negedge clk);
        check("ovf_sticky", 64'(ovf), 64'd1);

        // 130 words, one token back per launch: sent_cnt wraps to 2
        do_reset();
        fork
            for (int i = 0; i < 130; i++) send_word({$urandom, $urandom});
            begin
                ret = 0; cyc = 0; prev = sent;
                while (ret < 130 && cyc < 3000) begin
                    @(negedge clk);
                    cyc++;
                    if (sent != prev) begin
                        prev = sent;
                        ret++;
                        @(posedge clk);
                        #1 token = 1'b1;
                        @(posedge clk);
                        #1 token = 1'b0;
                    end
                end
                check("wrap_tokens", 64'(ret), 64'd130);
            end
        join
        repeat (8) @(negedge clk);
        check("wrap_sent", 64'(sent), 64'd2);
        check("wrap_credit", 64'(credit), 64'd16);
        check("wrap_ovf", 64'(ovf), 64'd0);

        // Reset during beat 2
        @(posedge clk);
        #1 valid = 1'b1; data = 64'h0123_4567_89ab_cdef;
        @(posedge clk);
        #1 valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midrst_valid", 64'(io_valid), 64'd0);
        check("midrst_data", 64'(io_data), 64'd0);
        check("midrst_credit", 64'(credit), 64'd16);
        check("midrst_sent", 64'(sent), 64'd0);
        check("midrst_ready", 64'(ready), 64'd1);

        // Four 4-bit channels, two beats per word
        @(posedge clk);
        #1 valid_b = 1'b1; data_b = 32'h8765_4321;
        @(posedge clk);
        #1 valid_b = 1'b0;
        @(negedge clk);
        check("b_beat0_valid", 64'(io_valid_b), 64'd1);
        check("b_beat0", 64'(io_data_b), 64'h7531);
        @(negedge clk);
        check("b_beat1_valid", 64'(io_valid_b), 64'd1);
        check("b_beat1", 64'(io_data_b), 64'h8642);
        @(negedge clk);
        check("b_done_valid", 64'(io_valid_b), 64'd0);
        check("b_done_data", 64'(io_data_b), 64'd0);
        check("b_credit", 64'(credit_b), 64'd15);
        check("b_sent", 64'(sent_b), 64'd1);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
